// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel fan-controller clock divider.
// The ratio constants assume the fan controller's 50 MHz system clock.
package clk_div_pkg;

    localparam int CNT_W_DFLT       = 32;
    localparam int DEFAULT_DIV_DFLT = 1000;

    localparam int DIV_MAX_CH  = 16;
    localparam int DIV_MAX_W   = 64;
    localparam int DIV_BUS_MAX = DIV_MAX_CH * DIV_MAX_W;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;
    localparam int unsigned DIV_100HZ  = SYS_CLK_HZ / 100;
    localparam int unsigned DIV_1KHZ   = SYS_CLK_HZ / 1_000;
    localparam int unsigned DIV_25KHZ  = SYS_CLK_HZ / 25_000;

    // Returns channel ch's slice of a flattened divisor bus; the caller narrows it to its width.
    function automatic logic [DIV_MAX_W-1:0] div_slice(
        input logic [DIV_BUS_MAX-1:0] bus,
        input int                     ch,
        input int                     w
    );
        return DIV_MAX_W'(bus >> (ch * w));
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and registered
// tick / square-wave outputs. Divisor changes are applied only at a period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DFLT,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV_DFLT)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] nxt;
    logic             pv;

    logic             act_nz;
    logic [CNT_W-1:0] last;
    logic             wrap;
    logic             hi_half;
    logic             tick_p1;
    logic             clk_p1;

    // act-1 is only formed for a nonzero divisor so the compare never sees an underflow.
    assign act_nz  = (act != '0);
    assign last    = act_nz ? (act - CNT_W'(1)) : '0;
    assign wrap    = act_nz && (cnt == last);
    assign hi_half = (act > CNT_W'(1)) && (cnt >= (act >> 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act     <= RST_DIV;
            nxt     <= '0;
            pv      <= 1'b0;
            tick_p1 <= 1'b0;
            clk_p1  <= 1'b0;
        end else begin
            if (div_load) begin
                nxt <= div_val;
            end

            if (sync_clr || wrap) begin
                // A load landing on the boundary bypasses nxt and takes effect right here.
                if (div_load) begin
                    act <= div_val;
                end else if (pv) begin
                    act <= nxt;
                end
                cnt <= '0;
                pv  <= 1'b0;
            end else if (!act_nz) begin
                // Disabled channel: a pending divisor goes live without waiting for a wrap.
                if (pv) begin
                    act <= nxt;
                end
                cnt <= '0;
                pv  <= div_load;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (div_load) begin
                    pv <= 1'b1;
                end
            end

            // ---- output stage p1 ----
            tick_p1 <= !sync_clr && wrap;
            clk_p1  <= !sync_clr && hi_half;
        end
    end

    assign tick    = tick_p1;
    assign clk_out = clk_p1;
    assign pend    = pv;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing
// one clock, with a global sync_clr that realigns every channel to count zero.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int              NUM_CH      = 4,
    parameter int              CNT_W       = CNT_W_DFLT,
    parameter longint unsigned DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       pend
);

    if (NUM_CH < 1 || NUM_CH > DIV_MAX_CH) begin : g_bad_num_ch
        $error("clk_div_multi: NUM_CH must be in 1..%0d", DIV_MAX_CH);
    end
    if (CNT_W < 1 || CNT_W > DIV_MAX_W) begin : g_bad_cnt_w
        $error("clk_div_multi: CNT_W must be in 1..%0d", DIV_MAX_W);
    end

    logic [DIV_BUS_MAX-1:0] div_bus;
    logic [NUM_CH-1:0]      clr_fan;

    assign div_bus = DIV_BUS_MAX'(div_in);
    assign clr_fan = {NUM_CH{sync_clr}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_val;

        assign div_val = CNT_W'(div_slice(div_bus, i, CNT_W));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(DEFAULT_DIV))
        ) u_chan (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .sync_clr (clr_fan[i]),
            .div_val  (div_val),
            .div_load (div_load[i]),
            .tick     (tick[i]),
            .clk_out  (clk_out[i]),
            .pend     (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: reset behaviour, ratio changes at period
// boundaries, disabled channels, boundary loads, sync_clr realignment and mid-period reset.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b1;
    logic [NCH*W-1:0] div_in = '0;
    logic [NCH-1:0]   div_load = '0;
    logic             sync_clr = 1'b0;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   pend;

    int n_pass  = 0;
    int n_total = 0;

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (W),
        .DEFAULT_DIV (1000)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .div_in   (div_in),
        .div_load (div_load),
        .sync_clr (sync_clr),
        .tick     (tick),
        .clk_out  (clk_out),
        .pend     (pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected outputs k edges after a period start where cnt was 0 (k=0 is the start itself).
    function automatic logic f_tick(input int a, input int k);
        if (a == 0 || k <= 0) return 1'b0;
        if (a == 1) return 1'b1;
        return (k % a) == 0;
    endfunction

    function automatic logic f_clk(input int a, input int k);
        if (a < 2 || k <= 0) return 1'b0;
        return ((k - 1) % a) >= (a / 2);
    endfunction

    task automatic chk_all(input string ph, input int k,
                           input logic [3:0] et, input logic [3:0] ec, input logic [3:0] ep);
        chk($sformatf("%s tick k=%0d", ph, k), 32'(tick), 32'(et));
        chk($sformatf("%s clk_out k=%0d", ph, k), 32'(clk_out), 32'(ec));
        chk($sformatf("%s pend k=%0d", ph, k), 32'(pend), 32'(ep));
    endtask

    task automatic run_default(input string ph, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) step();
            chk_all(ph, k, {4{f_tick(1000, k)}}, {4{f_clk(1000, k)}}, 4'b0000);
        end
    endtask

    task automatic do_sync(input logic [3:0] ld, input int a0, input int a1, input int a2, input int a3);
        div_in[0*W +: W] = a0;
        div_in[1*W +: W] = a1;
        div_in[2*W +: W] = a2;
        div_in[3*W +: W] = a3;
        div_load = ld;
        sync_clr = 1'b1;
        step();
        div_load = '0;
        sync_clr = 1'b0;
        chk_all("sync", 0, 4'b0000, 4'b0000, 4'b0000);
    endtask

    logic [3:0] et, ec, ep;

    initial begin
        // Power-on reset and default ratio
        rst_n = 1'b0;
        repeat (3) step();
        chk_all("reset", 0, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        run_default("dflt", 2000);

        // Ratio change mid-period, load 0 and disabled-channel load
        do_sync(4'b1111, 4, 5, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            step();
            div_load = '0;
            if (k == 13) begin div_in[0*W +: W] = 6; div_load[0] = 1'b1; end
            if (k == 17) begin div_in[1*W +: W] = 0; div_load[1] = 1'b1; end
            if (k == 3)  begin div_in[3*W +: W] = 8; div_load[3] = 1'b1; end
            et[0] = (k <= 16) ? f_tick(4, k) : f_tick(6, k - 16);
            ec[0] = (k <= 16) ? f_clk(4, k)  : f_clk(6, k - 16);
            et[1] = (k <= 20) ? f_tick(5, k) : 1'b0;
            ec[1] = (k <= 20) ? f_clk(5, k)  : 1'b0;
            et[2] = f_tick(1, k);
            ec[2] = f_clk(1, k);
            et[3] = (k <= 5) ? 1'b0 : f_tick(8, k - 5);
            ec[3] = (k <= 5) ? 1'b0 : f_clk(8, k - 5);
            ep = {k == 4, 1'b0, (k == 18 || k == 19), (k == 14 || k == 15)};
            chk_all("chg", k, et, ec, ep);
        end

        // Load on the wrap cycle, and last-load-wins within a period
        do_sync(4'b1111, 4, 4, 3, 0);
        for (int k = 1; k <= 25; k++) begin
            step();
            div_load = '0;
            if (k == 3) begin div_in[0*W +: W] = 2; div_load[0] = 1'b1; end
            if (k == 1) begin div_in[1*W +: W] = 7; div_load[1] = 1'b1; end
            if (k == 2) begin div_in[1*W +: W] = 9; div_load[1] = 1'b1; end
            et[0] = (k <= 4) ? f_tick(4, k) : f_tick(2, k - 4);
            ec[0] = (k <= 4) ? f_clk(4, k)  : f_clk(2, k - 4);
            et[1] = (k <= 4) ? f_tick(4, k) : f_tick(9, k - 4);
            ec[1] = (k <= 4) ? f_clk(4, k)  : f_clk(9, k - 4);
            et[2] = f_tick(3, k);
            ec[2] = f_clk(3, k);
            et[3] = 1'b0;
            ec[3] = 1'b0;
            ep = {2'b00, (k == 2 || k == 3), 1'b0};
            chk_all("wrapld", k, et, ec, ep);
        end

        // Channels at different phases, then realigned by sync_clr
        do_sync(4'b1111, 3, 4, 0, 4);
        for (int k = 1; k <= 10; k++) begin
            step();
            div_load = '0;
            if (k == 2) begin div_in[2*W +: W] = 3; div_load[2] = 1'b1; end
            et = {f_tick(4, k), (k <= 4) ? 1'b0 : f_tick(3, k - 4), f_tick(4, k), f_tick(3, k)};
            ec = {f_clk(4, k),  (k <= 4) ? 1'b0 : f_clk(3, k - 4),  f_clk(4, k),  f_clk(3, k)};
            ep = {1'b0, k == 3, 2'b00};
            chk_all("phase", k, et, ec, ep);
        end
        do_sync(4'b0000, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            et = {f_tick(4, k), f_tick(3, k), f_tick(4, k), f_tick(3, k)};
            ec = {f_clk(4, k),  f_clk(3, k),  f_clk(4, k),  f_clk(3, k)};
            chk_all("align", k, et, ec, 4'b0000);
        end

        // Pending value discarded by an asynchronous mid-period reset
        div_in[1*W +: W] = 7;
        div_load = 4'b0010;
        step();
        div_load = '0;
        chk("pend before reset", 32'(pend), 32'(4'b0010));
        #3 rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        rst_n = 1'b1;
        run_default("postrst", 1001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock divider, successor to the single fixed-ratio divider in the fan controller clock tree. Each channel divides clk_in by a runtime-programmable ratio and produces two outputs: a one-cycle tick enable, for PWM and RPM-sampling logic, and a registered square wave, for the display and buzzer paths. Ratio changes take effect only at a period boundary, so they never produce a runt pulse. A global sync_clr realigns all channels.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 32, counter and divisor width in bits
DEFAULT_DIV, 1000, active divisor loaded into every channel at reset (must be less than 2^CNT_W)

Ports:
clk_in  input  1  single system clock
rst_n  input  1  asynchronous active-low reset
div_in  input  NUM_CH*CNT_W  per-channel divisor; channel i occupies bits [i*CNT_W +: CNT_W]
div_load  input  NUM_CH  per-channel strobe; captures div_in slice i on the clock edge where it is high
sync_clr  input  1  synchronous realign of all channels
tick  output  NUM_CH  one-cycle pulse per divided period
clk_out  output  NUM_CH  divided square wave
pend  output  NUM_CH  divisor captured but not yet applied

Behaviour:
- Clocking and reset:
  - Single clock domain, clk_in, rising edge.
  - rst_n is asynchronous and active-low.
- Per-channel state:
  - cnt[CNT_W]: period counter.
  - act[CNT_W]: active divisor.
  - nxt[CNT_W]: pending divisor.
  - pv: pending-valid flag.
- Reset values:
  - cnt=0, act=DEFAULT_DIV, nxt=0, pv=0.
  - tick=0, clk_out=0, pend=0.
- Counting:
  - When act is nonzero, cnt counts 0..act-1.
  - wrap = (act!=0) && (cnt==act-1).
  - On wrap, cnt returns to 0.
- tick: registered; tick <= wrap. It is high for exactly one clk_in cycle, one cycle after the last count of a period.
- clk_out: registered.
  - act>=2: clk_out <= (cnt >= act>>1). The wave is low for floor(act/2) cycles, then high for ceil(act/2) cycles.
  - act=1: tick is high continuously and clk_out is held 0.
  - act=0: the channel is disabled; cnt is frozen at 0 and tick=clk_out=0.
- Divisor load:
  - On div_load[i], nxt <= div_in slice and pv <= 1.
  - A second load before the value is applied overwrites nxt; the last load wins.
- Apply (act <= nxt, cnt <= 0, pv <= 0) occurs when any of these is true:
  - wrap is true in that cycle.
  - act==0 (disabled channel; applied on the next edge).
  - sync_clr is high.
- Simultaneous load and wrap in the same cycle: the newly loaded value bypasses nxt and becomes act at that wrap; pv stays 0.
- Simultaneous load and sync_clr: the loaded value becomes act and cnt=0.
- sync_clr: all channels go to cnt=0 and apply any pending value. tick and clk_out read 0 on the next cycle. Relative phase is then identical across channels with equal act.
- pend output mirrors pv.
- Arithmetic:
  - All comparisons are unsigned at CNT_W bits.
  - act-1 is computed only when act is nonzero, so no underflow reaches the compare.
  - cnt never exceeds act-1, so there is no counter overflow for any legal act.
- Reset mid-period: reset forces the reset values immediately. Any pending value is discarded.

Decomposition:
- Shared package clk_div_pkg:
  - default CNT_W and DEFAULT_DIV constants.
  - Named ratio constants for the 100 Hz, 1 kHz and 25 kHz fan-PWM enables.
  - A function that returns a channel's slice from the flattened div_in bus.
- One sub-module: clk_div_chan, a single channel holding cnt/act/nxt/pv and the output registers. The top level is a generate loop over NUM_CH plus a sync_clr fan-out.

Test Plan:
- Reset release with DEFAULT_DIV=1000 -> first tick on cycle 1000 after release, then every 1000 cycles; clk_out low for 500 cycles and high for 500; pend=0 throughout.
- Channel 0 running with act=4, div_load with 6 at cnt=1 -> pend=1 until the wrap; the current 4-cycle period completes unchanged; the next period is 6 cycles (3 low / 3 high); pend clears at the wrap.
- Odd ratio and edge cases, act=5 on channel 1 -> clk_out 2 low / 3 high, tick every 5 cycles; act=1 -> tick constantly 1, clk_out 0; load 0 -> outputs 0 from the wrap onward.
- Disabled channel (act=0), load 8 -> applied on the next edge with no wait for a wrap; first tick 8 cycles after apply.
- Load on the exact wrap cycle, act=4, load 2 -> the next period is 2 cycles and pend never asserts. Loads of 7 then 9 within one period -> 9 applied.
- Four channels with act=3, 4, 3, 4 started at different phases, then a one-cycle sync_clr -> all cnt=0 and outputs 0 the next cycle. Channels 0 and 2 tick in the same cycle thereafter; reset asserted mid-period returns every channel to act=1000 and pend=0.
